// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single fixed-latency RAM port.
// One access is in flight at a time, and every output comes straight from a register.
module mem_arbiter #(
    parameter int RAM_LATENCY = 2
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic [1:0]  I_exec,
    input  logic [1:0]  I_write,
    input  logic [3:0]  I_size,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_data,
    output logic [1:0]  O_ready,
    output logic [1:0]  O_data_ready,
    output logic [15:0] O_data,
    output logic        O_ram_enable,
    output logic        O_ram_write,
    output logic [1:0]  O_ram_size,
    output logic [15:0] O_ram_addr,
    output logic [15:0] O_ram_data,
    input  logic [15:0] I_ram_data,
    output logic        O_grant
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RAM_LATENCY - 1);

    state_t      r_state;
    logic [2:0]  r_count;
    logic [1:0]  r_ready;
    logic [1:0]  r_data_ready;
    logic [15:0] r_data;
    logic        r_ram_enable;
    logic        r_ram_write;
    logic [1:0]  r_ram_size;
    logic [15:0] r_ram_addr;
    logic [15:0] r_ram_data;
    logic        r_grant;

    logic [1:0]  w_req;
    logic        w_any;
    logic        w_pick;
    logic        w_sel_write;
    logic [1:0]  w_sel_size;
    logic [15:0] w_sel_addr;
    logic [15:0] w_sel_data;
    logic [1:0]  w_done_vec;

    // Only requests that can actually be accepted take part in arbitration.
    assign w_req  = I_exec & r_ready;
    assign w_any  = |w_req;
    assign w_pick = (&w_req) ? ~r_grant : w_req[1];

    assign w_sel_write = I_write[w_pick];
    assign w_sel_size  = w_pick ? I_size[3:2]   : I_size[1:0];
    assign w_sel_addr  = w_pick ? I_addr[31:16] : I_addr[15:0];
    assign w_sel_data  = w_pick ? I_data[31:16] : I_data[15:0];
    assign w_done_vec  = r_grant ? 2'b10 : 2'b01;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state      <= S_IDLE;
            r_count      <= 3'd0;
            r_ready      <= 2'b11;
            r_data_ready <= 2'b00;
            r_data       <= 16'h0000;
            r_ram_enable <= 1'b0;
            r_ram_write  <= 1'b0;
            r_ram_size   <= 2'b00;
            r_ram_addr   <= 16'h0000;
            r_ram_data   <= 16'h0000;
            r_grant      <= 1'b1;
        end else begin
            r_data_ready <= 2'b00;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_ISSUE;
                        r_ram_enable <= 1'b1;
                        r_ready      <= 2'b00;
                        r_grant      <= w_pick;
                        r_ram_write  <= w_sel_write;
                        r_ram_size   <= w_sel_size;
                        r_ram_addr   <= w_sel_addr;
                        r_ram_data   <= w_sel_data;
                    end
                end
                S_ISSUE: begin
                    r_ram_enable <= 1'b0;
                    r_count      <= LAT_LOAD;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_count == 3'd0) begin
                        r_data_ready <= w_done_vec;
                        r_ready      <= 2'b11;
                        r_state      <= S_IDLE;
                        if (!r_ram_write) begin
                            r_data <= I_ram_data;
                        end
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign O_ready      = r_ready;
    assign O_data_ready = r_data_ready;
    assign O_data       = r_data;
    assign O_ram_enable = r_ram_enable;
    assign O_ram_write  = r_ram_write;
    assign O_ram_size   = r_ram_size;
    assign O_ram_addr   = r_ram_addr;
    assign O_ram_data   = r_ram_data;
    assign O_grant      = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default latency instance plus
// latency-1 and latency-5 instances for completion timing.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  exec;
    logic        exec_b;
    logic [1:0]  wr;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] ram_rdata;

    logic [1:0]  rdy, drdy;
    logic [15:0] odata, raddr, rdata_o;
    logic        ren, rwr, gnt;
    logic [1:0]  rsize;

    logic [1:0]  rdy1, drdy1, rsize1;
    logic [15:0] odata1, raddr1, rdata1;
    logic        ren1, rwr1, gnt1;

    logic [1:0]  rdy5, drdy5, rsize5;
    logic [15:0] odata5, raddr5, rdata5;
    logic        ren5, rwr5, gnt5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RAM_LATENCY(2)) dut (
        .I_clk(clk), .I_reset(rst), .I_exec(exec), .I_write(wr),
        .I_size(size), .I_addr(addr), .I_data(wdata),
        .O_ready(rdy), .O_data_ready(drdy), .O_data(odata),
        .O_ram_enable(ren), .O_ram_write(rwr), .O_ram_size(rsize),
        .O_ram_addr(raddr), .O_ram_data(rdata_o),
        .I_ram_data(ram_rdata), .O_grant(gnt)
    );

    mem_arbiter #(.RAM_LATENCY(1)) dut1 (
        .I_clk(clk), .I_reset(rst), .I_exec({1'b0, exec_b}), .I_write(wr),
        .I_size(size), .I_addr(addr), .I_data(wdata),
        .O_ready(rdy1), .O_data_ready(drdy1), .O_data(odata1),
        .O_ram_enable(ren1), .O_ram_write(rwr1), .O_ram_size(rsize1),
        .O_ram_addr(raddr1), .O_ram_data(rdata1),
        .I_ram_data(ram_rdata), .O_grant(gnt1)
    );

    mem_arbiter #(.RAM_LATENCY(5)) dut5 (
        .I_clk(clk), .I_reset(rst), .I_exec({1'b0, exec_b}), .I_write(wr),
        .I_size(size), .I_addr(addr), .I_data(wdata),
        .O_ready(rdy5), .O_data_ready(drdy5), .O_data(odata5),
        .O_ram_enable(ren5), .O_ram_write(rwr5), .O_ram_size(rsize5),
        .O_ram_addr(raddr5), .O_ram_data(rdata5),
        .I_ram_data(ram_rdata), .O_grant(gnt5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; exec = 2'b00; exec_b = 1'b0; wr = 2'b00;
        size = 4'h0; addr = 32'h0; wdata = 32'h0; ram_rdata = 16'h0;
        step(); step();
        rst = 1'b0;
        check("rst_ready", rdy, 2'b11);
        check("rst_grant", gnt, 1'b1);
        check("rst_data", odata, 16'h0);
        check("rst_en", ren, 1'b0);
        check("rst_addr", raddr, 16'h0);
        check("rst_drdy", drdy, 2'b00);

        // requester 0 read of 0x0010
        exec = 2'b01; wr = 2'b00; size = 4'b0010;
        addr = 32'h0000_0010; ram_rdata = 16'hBEEF;
        step();
        exec = 2'b00;
        check("rd_en_e0", ren, 1'b1);
        check("rd_addr", raddr, 16'h0010);
        check("rd_size", rsize, 2'b10);
        check("rd_ready_e0", rdy, 2'b00);
        check("rd_grant", gnt, 1'b0);
        step();
        check("rd_en_e1", ren, 1'b0);
        check("rd_drdy_e1", drdy, 2'b00);
        step();
        check("rd_drdy_e2", drdy, 2'b00);
        step();
        check("rd_drdy_e3", drdy, 2'b01);
        check("rd_data", odata, 16'hBEEF);
        check("rd_ready_e3", rdy, 2'b11);
        step();
        check("rd_drdy_e4", drdy, 2'b00);

        // requester 1 write 0x1234 to 0x0200, size 1
        exec = 2'b10; wr = 2'b10; size = 4'b0100;
        addr = 32'h0200_0000; wdata = 32'h1234_0000; ram_rdata = 16'hDEAD;
        step();
        exec = 2'b00;
        check("wr_write", rwr, 1'b1);
        check("wr_wdata", rdata_o, 16'h1234);
        check("wr_size", rsize, 2'b01);
        check("wr_addr", raddr, 16'h0200);
        check("wr_grant", gnt, 1'b1);
        step(); step(); step();
        check("wr_drdy", drdy, 2'b10);
        check("wr_data_kept", odata, 16'hBEEF);
        check("wr_hold_addr", raddr, 16'h0200);

        // both requesters hold exec for four transactions
        exec = 2'b11; wr = 2'b00; size = 4'b0000;
        addr = 32'h0B00_0A00; ram_rdata = 16'h7777;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_grant", gnt, (k % 2 == 0) ? 1'b0 : 1'b1);
            check("rr_addr", raddr, (k % 2 == 0) ? 16'h0A00 : 16'h0B00);
            step(); step(); step();
            check("rr_drdy", drdy, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        exec = 2'b00;
        step();

        // requester 1 arrives mid-transaction of requester 0
        exec = 2'b01; addr = 32'h0C00_0C01;
        step();
        check("mid_grant0", gnt, 1'b0);
        exec = 2'b10;
        step(); step();
        check("mid_ignored_grant", gnt, 1'b0);
        check("mid_ignored_addr", raddr, 16'h0C01);
        check("mid_ignored_drdy", drdy, 2'b00);
        step();
        check("mid_drdy0", drdy, 2'b01);
        step();
        check("mid_grant1", gnt, 1'b1);
        check("mid_addr1", raddr, 16'h0C00);
        check("mid_no_dup", drdy, 2'b00);
        exec = 2'b00;
        step(); step();
        check("mid_drdy_e2", drdy, 2'b00);
        step();
        check("mid_drdy1", drdy, 2'b10);

        // reset while waiting
        exec = 2'b01; wr = 2'b01; addr = 32'h0000_0F0F; wdata = 32'h0000_4444;
        size = 4'b0011;
        step();
        exec = 2'b00;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wrst_drdy", drdy, 2'b00);
        check("wrst_ready", rdy, 2'b11);
        check("wrst_grant", gnt, 1'b1);
        check("wrst_data", odata, 16'h0);
        check("wrst_en", ren, 1'b0);
        check("wrst_write", rwr, 1'b0);
        check("wrst_size", rsize, 2'b00);
        check("wrst_addr", raddr, 16'h0);
        check("wrst_wdata", rdata_o, 16'h0);
        step();
        check("wrst_idle_drdy", drdy, 2'b00);
        exec = 2'b11; wr = 2'b00; addr = 32'h0022_0011; ram_rdata = 16'h5A5A;
        step();
        exec = 2'b00;
        check("post_rst_grant", gnt, 1'b0);
        check("post_rst_addr", raddr, 16'h0011);
        step(); step(); step();
        check("post_rst_drdy", drdy, 2'b01);
        check("post_rst_data", odata, 16'h5A5A);

        // latency 1 and 5 completion timing
        wr = 2'b00; addr = 32'h0000_0033; ram_rdata = 16'hC0DE;
        exec_b = 1'b1;
        step();
        exec_b = 1'b0;
        check("lat_en1", ren1, 1'b1);
        check("lat_en5", ren5, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("lat1_drdy", drdy1, (k == 2) ? 2'b01 : 2'b00);
            check("lat5_drdy", drdy5, (k == 6) ? 2'b01 : 2'b00);
        end
        check("lat1_data", odata1, 16'hC0DE);
        check("lat5_data", odata5, 16'hC0DE);
        check("lat_main_idle", drdy, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
